// File: rtl/alu_seq_unit.sv
// Sequential ALU: funct decode, 1-cycle ops, iterative 1-bit shifter.
// Define ALU_SEQ_BARREL_EN to replace the iterative shifter with a barrel shifter.
module alu_seq_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      ALUOperation,
    input  logic [6:0]      Funct7,
    input  logic [2:0]      Funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    localparam int SHW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR,
        OP_SRL, OP_SRA, OP_OR, OP_AND, OP_ILL
    } op_t;

    state_t          state, state_d;
    op_t             op, sh_op;
    logic [XLEN-1:0] res_q, alu_res, step;
    logic [SHW-1:0]  cnt, shamt;
    logic            zero_q, ill_q;
    logic            accept, is_shift, go_shift;
    logic            f7_zero, f7_alt, itype;

    function automatic logic [XLEN-1:0] step1(input logic [XLEN-1:0] v, input op_t k);
        unique case (k)
            OP_SLL:  step1 = {v[XLEN-2:0], 1'b0};
            OP_SRA:  step1 = {v[XLEN-1], v[XLEN-1:1]};
            default: step1 = {1'b0, v[XLEN-1:1]};
        endcase
    endfunction

    assign shamt   = op_b[SHW-1:0];
    assign f7_zero = (Funct7 == 7'b0000000);
    assign f7_alt  = (Funct7 == 7'b0100000);
    assign itype   = ALUOperation[0];

    // I-type only checks funct7 for the shift encodings
    always_comb begin
        op = OP_ILL;
        unique case (ALUOperation)
            2'b00: op = OP_ADD;
            2'b01: op = OP_SUB;
            default: begin
                unique case (Funct3)
                    3'b000: if (itype || f7_zero) op = OP_ADD;
                            else if (f7_alt) op = OP_SUB;
                    3'b001: if (f7_zero) op = OP_SLL;
                    3'b010: if (itype || f7_zero) op = OP_SLT;
                    3'b011: if (itype || f7_zero) op = OP_SLTU;
                    3'b100: if (itype || f7_zero) op = OP_XOR;
                    3'b101: if (f7_zero) op = OP_SRL;
                            else if (f7_alt) op = OP_SRA;
                    3'b110: if (itype || f7_zero) op = OP_OR;
                    default: if (itype || f7_zero) op = OP_AND;
                endcase
            end
        endcase
    end

    always_comb begin
        alu_res = '0;
        unique case (op)
            OP_ADD:  alu_res = op_a + op_b;
            OP_SUB:  alu_res = op_a - op_b;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_AND:  alu_res = op_a & op_b;
            OP_SLL, OP_SRL, OP_SRA: begin
`ifdef ALU_SEQ_BARREL_EN
                if (op == OP_SLL)      alu_res = op_a << shamt;
                else if (op == OP_SRL) alu_res = op_a >> shamt;
                else                   alu_res = $signed(op_a) >>> shamt;
`else
                // first bit is shifted on the accept edge
                alu_res = (shamt == '0) ? op_a : step1(op_a, op);
`endif
            end
            default: alu_res = '0;
        endcase
    end

    assign is_shift = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
`ifdef ALU_SEQ_BARREL_EN
    assign go_shift = 1'b0;
`else
    assign go_shift = is_shift && (shamt > SHW'(1));
`endif

    assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept   = in_valid && in_ready;
    assign step     = step1(res_q, sh_op);

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:  if (accept) state_d = go_shift ? SHIFT : DONE;
            SHIFT: if (cnt == SHW'(1)) state_d = DONE;
            DONE:  if (accept) state_d = go_shift ? SHIFT : DONE;
                   else if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            res_q  <= '0;
            zero_q <= 1'b0;
            ill_q  <= 1'b0;
            cnt    <= '0;
            sh_op  <= OP_ADD;
        end else begin
            state <= state_d;
            if (accept) begin
                res_q  <= alu_res;
                ill_q  <= (op == OP_ILL);
                sh_op  <= op;
                cnt    <= shamt - SHW'(1);
                zero_q <= go_shift ? 1'b0 : (alu_res == '0);
            end else if (state == SHIFT) begin
                res_q <= step;
                cnt   <= cnt - SHW'(1);
                if (cnt == SHW'(1)) zero_q <= (step == '0);
            end
        end
    end

    assign out_valid = (state == DONE);
    assign result    = res_q;
    assign zero      = zero_q;
    assign illegal   = ill_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Scoreboard bench for alu_seq_unit: directed vectors, decoupled monitor.
module tb_alu_seq_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready;
    logic [1:0]  ALUOperation;
    logic [6:0]  Funct7;
    logic [2:0]  Funct3;
    logic [31:0] op_a, op_b, result;
    logic        out_valid, out_ready, zero, illegal;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [31:0] r;
        logic        z;
        logic        il;
        int          acc;
        int          lat;
    } exp_t;

    exp_t q[$];
    bit   seen = 1'b0;

    alu_seq_unit #(.XLEN(32)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .ALUOperation(ALUOperation), .Funct7(Funct7), .Funct3(Funct3),
        .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .illegal(illegal)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic int shl(input int n);
`ifdef ALU_SEQ_BARREL_EN
        return 1;
`else
        return (n == 0) ? 1 : n;
`endif
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_valid: got result %h want no output", result);
                end else begin
                    if (!seen) begin
                        seen = 1'b1;
                        chk("latency", 32'(cyc - q[0].acc), 32'(q[0].lat));
                    end
                    chk("result", result, q[0].r);
                    chk("zero", 32'(zero), 32'(q[0].z));
                    chk("illegal", 32'(illegal), 32'(q[0].il));
                    if (!out_ready) chk("bp_in_ready", 32'(in_ready), 32'd0);
                    else begin
                        q.delete(0);
                        seen = 1'b0;
                    end
                end
            end else if (q.size() > 0 && cyc > q[0].acc) begin
                chk("busy_in_ready", 32'(in_ready), 32'd0);
            end
        end
    end

    task automatic issue(input logic [1:0] aop, input logic [6:0] f7, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r, input logic il, input int lat);
        exp_t e;
        bit   ok = 1'b0;
        ALUOperation = aop;
        Funct7       = f7;
        Funct3       = f3;
        op_a         = a;
        op_b         = b;
        in_valid     = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) begin
                e.r   = r;
                e.z   = (r == 32'd0);
                e.il  = il;
                e.acc = cyc;
                e.lat = lat;
                q.push_back(e);
                ok = 1'b1;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got in_ready 0 want 1");
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && q.size() > 0; i++) @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: got %0d pending want 0", q.size());
            q.delete();
            seen = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        in_valid     = 1'b0;
        out_ready    = 1'b1;
        ALUOperation = 2'b00;
        Funct7       = 7'd0;
        Funct3       = 3'd0;
        op_a         = '0;
        op_b         = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_zero", 32'(zero), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        issue(2'b10, 7'b0100000, 3'b000, 32'd5, 32'd7, 32'hFFFFFFFE, 1'b0, 1);
        drain();
        issue(2'b10, 7'b0100000, 3'b101, 32'h80000000, 32'd4, 32'hF8000000, 1'b0, shl(4));
        drain();
        issue(2'b10, 7'b0000000, 3'b001, 32'd0, 32'd0, 32'd0, 1'b0, 1);
        drain();
        issue(2'b10, 7'b0000000, 3'b011, 32'd1, 32'd2, 32'd1, 1'b0, 1);
        drain();
        issue(2'b10, 7'b0000001, 3'b000, 32'd9, 32'd9, 32'd0, 1'b1, 1);
        drain();
        issue(2'b10, 7'b0000000, 3'b010, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, 1);
        drain();
        issue(2'b10, 7'b0000000, 3'b011, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 1);
        drain();
        issue(2'b10, 7'b0000000, 3'b101, 32'hF0000000, 32'hFFFFFFFF, 32'd1, 1'b0, shl(31));
        drain();
        issue(2'b11, 7'b0000000, 3'b001, 32'd1, 32'd1, 32'd2, 1'b0, 1);
        drain();
        issue(2'b11, 7'b0100000, 3'b001, 32'd1, 32'd1, 32'd0, 1'b1, 1);
        drain();
        issue(2'b10, 7'b0000000, 3'b110, 32'h12340000, 32'h00005678, 32'h12345678, 1'b0, 1);
        drain();
        issue(2'b11, 7'b1010101, 3'b111, 32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 1'b0, 1);
        drain();
        issue(2'b10, 7'b0000001, 3'b100, 32'd3, 32'd5, 32'd0, 1'b1, 1);
        drain();
        issue(2'b01, 7'b1111111, 3'b111, 32'd0, 32'd1, 32'hFFFFFFFF, 1'b0, 1);
        drain();
        issue(2'b11, 7'b0100000, 3'b101, 32'h40000000, 32'd2, 32'h10000000, 1'b0, shl(2));
        drain();

        out_ready = 1'b0;
        issue(2'b10, 7'b0000000, 3'b100, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'd0, 1'b0, 1);
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
        issue(2'b00, 7'b0000000, 3'b000, 32'd2, 32'd3, 32'd5, 1'b0, 1);
        drain();

        issue(2'b10, 7'b0000000, 3'b101, 32'hFFFF0000, 32'd20, 32'h00000FFF, 1'b0, shl(20));
        repeat (4) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_result", result, 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        q.delete();
        seen = 1'b0;
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        issue(2'b11, 7'b1111111, 3'b000, 32'd10, 32'd20, 32'd30, 1'b0, 1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
